// File: rtl/dual_port_ram_arbiter.sv
// Shared-write-port RAM: two writers arbitrated round-robin with a burst limit,
// plus an independent 1-cycle read port that returns old data on same-edge collisions.
module dual_port_ram_arbiter #(
    parameter int length    = 4,
    parameter int locations = 8,
    parameter int burst     = 4,
    parameter int AW        = $clog2(locations)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req0,
    input  logic [AW-1:0]     wr_addr0,
    input  logic [length-1:0] wr_data0,
    output logic              wr_gnt0,
    input  logic              wr_req1,
    input  logic [AW-1:0]     wr_addr1,
    input  logic [length-1:0] wr_data1,
    output logic              wr_gnt1,
    input  logic              rd_req,
    input  logic [AW-1:0]     rd_addr,
    output logic              rd_valid,
    output logic [length-1:0] rd_data
);

    localparam int CW = $clog2(burst) + 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(burst - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              we0_s, we1_s;
    logic              wr_en_s;
    logic [AW-1:0]     wr_addr_s;
    logic [length-1:0] wr_data_s;
    logic [length-1:0] mem_q [locations];
    logic              rd_valid_q;
    logic [length-1:0] rd_data_q;

    // Arbiter state, last-served flag (1 = writer 1 served last) and burst count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the owner writes on every cycle its request stays high.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        we0_s   = 1'b0;
        we1_s   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (wr_req0 && wr_req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (wr_req0) begin
                    state_d = OWN0;
                end else if (wr_req1) begin
                    state_d = OWN1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0: begin
                if (!wr_req0) begin
                    state_d = wr_req1 ? OWN1 : IDLE;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    we0_s = 1'b1;
                    if (cnt_q == BURST_LAST) begin
                        cnt_d = '0;
                        if (wr_req1) begin
                            state_d = OWN1;
                            last_d  = 1'b0;
                        end else begin
                            state_d = OWN0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            OWN1: begin
                if (!wr_req1) begin
                    state_d = wr_req0 ? OWN0 : IDLE;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    we1_s = 1'b1;
                    if (cnt_q == BURST_LAST) begin
                        cnt_d = '0;
                        if (wr_req0) begin
                            state_d = OWN0;
                            last_d  = 1'b1;
                        end else begin
                            state_d = OWN1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Steer the owning writer onto the single write port.
    always_comb begin
        wr_en_s   = we0_s | we1_s;
        wr_addr_s = wr_addr0;
        wr_data_s = wr_data0;
        if (we1_s) begin
            wr_addr_s = wr_addr1;
            wr_data_s = wr_data1;
        end else begin
            wr_addr_s = wr_addr0;
            wr_data_s = wr_data0;
        end
    end

    // Memory array: not reset, and never written while reset is asserted.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
    end

    // Read port samples the pre-edge array contents, giving read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else if (rd_req) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= mem_q[rd_addr];
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

    assign wr_gnt0  = (state_q == OWN0);
    assign wr_gnt1  = (state_q == OWN1);
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Directed bench for dual_port_ram_arbiter: expected grants per cycle plus a
// memory model feeding a read scoreboard.
module tb_dual_port_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_req0 = 1'b0, wr_req1 = 1'b0, rd_req = 1'b0;
    logic [2:0] wr_addr0 = 3'd0, wr_addr1 = 3'd0, rd_addr = 3'd0;
    logic [3:0] wr_data0 = 4'd0, wr_data1 = 4'd0;
    logic       wr_gnt0, wr_gnt1, rd_valid;
    logic [3:0] rd_data;

    int total = 0;
    int bad   = 0;

    logic [3:0] model_mem [8];
    bit         model_known [8];
    logic [3:0] exp_q [$];
    bit         kn_q [$];
    logic       prev_g0 = 1'b0, prev_g1 = 1'b0;

    dual_port_ram_arbiter #(.length(4), .locations(8), .burst(4)) dut (
        .clk(clk), .rst(rst),
        .wr_req0(wr_req0), .wr_addr0(wr_addr0), .wr_data0(wr_data0), .wr_gnt0(wr_gnt0),
        .wr_req1(wr_req1), .wr_addr1(wr_addr1), .wr_data1(wr_data1), .wr_gnt1(wr_gnt1),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record expected read and write effects, then check after the edge.
    task automatic tick(input logic eg0, input logic eg1, input string tag);
        bit         had_rd;
        logic [3:0] e;
        bit         k;
        had_rd = rd_req;
        if (rd_req) begin
            exp_q.push_back(model_mem[rd_addr]);
            kn_q.push_back(model_known[rd_addr]);
        end
        if (prev_g0 && wr_req0) begin
            model_mem[wr_addr0]   = wr_data0;
            model_known[wr_addr0] = 1'b1;
        end
        if (prev_g1 && wr_req1) begin
            model_mem[wr_addr1]   = wr_data1;
            model_known[wr_addr1] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, "_gnt0"}, 32'(wr_gnt0), 32'(eg0));
        chk({tag, "_gnt1"}, 32'(wr_gnt1), 32'(eg1));
        chk({tag, "_excl"}, 32'(wr_gnt0 & wr_gnt1), 32'd0);
        if (had_rd) begin
            chk({tag, "_rvalid"}, 32'(rd_valid), 32'd1);
            e = exp_q.pop_front();
            k = kn_q.pop_front();
            if (k) chk({tag, "_rdata"}, 32'(rd_data), 32'(e));
        end else begin
            chk({tag, "_rvalid"}, 32'(rd_valid), 32'd0);
        end
        prev_g0 = eg0;
        prev_g1 = eg1;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_req  = 1'b1;
            rd_addr = 3'(i);
            tick(prev_g0, prev_g1, tag);
        end
        rd_req = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_gnt0", 32'(wr_gnt0), 32'd0);
        chk("reset_gnt1", 32'(wr_gnt1), 32'd0);
        chk("reset_rvalid", 32'(rd_valid), 32'd0);
        chk("reset_rdata", 32'(rd_data), 32'd0);
        rst = 1'b0;

        // Single writer, then read back.
        wr_req0 = 1'b1; wr_addr0 = 3'd3; wr_data0 = 4'hA;
        tick(1'b1, 1'b0, "single_grant");
        tick(1'b1, 1'b0, "single_write");
        wr_req0 = 1'b0; rd_req = 1'b1; rd_addr = 3'd3;
        tick(1'b0, 1'b0, "single_read");
        rd_req = 1'b0;

        // Lone long burst by writer 1: no forced handover.
        wr_req1 = 1'b1; wr_addr1 = 3'd0; wr_data1 = 4'h0;
        tick(1'b0, 1'b1, "lone_grant");
        for (int i = 0; i < 10; i++) begin
            wr_addr1 = 3'(i % 8);
            wr_data1 = 4'(i + 3);
            tick(1'b0, 1'b1, "lone_burst");
        end
        wr_req1 = 1'b0;
        tick(1'b0, 1'b0, "lone_release");
        read_all("lone_readback");

        // Reset in the middle of a burst.
        wr_req0 = 1'b1; wr_addr0 = 3'd2; wr_data0 = 4'hC;
        rd_req = 1'b1; rd_addr = 3'd0;
        tick(1'b1, 1'b0, "rb_grant");
        tick(1'b1, 1'b0, "rb_write1");
        wr_addr0 = 3'd6; wr_data0 = 4'hE;
        rst = 1'b1;
        #2;
        chk("rb_async_gnt0", 32'(wr_gnt0), 32'd0);
        chk("rb_async_gnt1", 32'(wr_gnt1), 32'd0);
        chk("rb_async_rvalid", 32'(rd_valid), 32'd0);
        chk("rb_async_rdata", 32'(rd_data), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rb_hold_gnt0", 32'(wr_gnt0), 32'd0);
        chk("rb_hold_rvalid", 32'(rd_valid), 32'd0);
        prev_g0 = 1'b0;
        prev_g1 = 1'b0;
        rst = 1'b0;

        // Tie after reset: writer 0 first, 4-write bursts alternate.
        wr_req1 = 1'b1; wr_addr1 = 3'd7; wr_data1 = 4'h0;
        rd_req = 1'b1; rd_addr = 3'd6;
        tick(1'b1, 1'b0, "tie_grant");
        rd_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wr_addr0 = 3'(k % 4);
            wr_data0 = 4'(k + 1);
            wr_addr1 = 3'(4 + k % 4);
            wr_data1 = 4'(k + 8);
            if (k < 3)       tick(1'b1, 1'b0, "tie_own0");
            else if (k < 7)  tick(1'b0, 1'b1, "tie_own1");
            else             tick(1'b1, 1'b0, "tie_back0");
        end

        // Early release by writer 0 after two writes.
        wr_addr0 = 3'd1; wr_data0 = 4'h5;
        tick(1'b1, 1'b0, "rel_w1");
        wr_addr0 = 3'd2; wr_data0 = 4'h6;
        tick(1'b1, 1'b0, "rel_w2");
        wr_req0 = 1'b0;
        tick(1'b0, 1'b1, "rel_handover");
        wr_addr1 = 3'd3; wr_data1 = 4'hF;
        tick(1'b0, 1'b1, "rel_w1b");
        wr_req1 = 1'b0;
        tick(1'b0, 1'b0, "rel_idle");
        wr_req0 = 1'b1; wr_req1 = 1'b1;
        tick(1'b1, 1'b0, "rel_tie");
        wr_req0 = 1'b0; wr_req1 = 1'b0;
        tick(1'b0, 1'b0, "rel_drop");

        // Same-edge read/write collision.
        wr_req0 = 1'b1; wr_addr0 = 3'd5; wr_data0 = 4'h3;
        tick(1'b1, 1'b0, "col_grant");
        tick(1'b1, 1'b0, "col_w");
        wr_data0 = 4'h9; rd_req = 1'b1; rd_addr = 3'd5;
        tick(1'b1, 1'b0, "col_same");
        wr_req0 = 1'b0;
        tick(1'b0, 1'b0, "col_next");
        rd_req = 1'b0;
        tick(1'b0, 1'b0, "col_idle");

        read_all("final_readback");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_arbiter.md
DUAL_PORT_RAM_ARBITER -- requirements
Module: dual_port_ram_arbiter

Interface
REQ-001 The block SHALL have parameter length, default 4, meaning data word width in bits.
REQ-002 The block SHALL have parameter locations, default 8, meaning memory depth in words; address width AW = $clog2(locations).
REQ-003 The block SHALL have parameter burst, default 4, meaning the maximum number of consecutive writes one writer may perform while the other writer is requesting.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 wr_req0  input  1  writer 0 request; held high while writer 0 has data to write.
REQ-007 wr_addr0  input  AW  writer 0 address.
REQ-008 wr_data0  input  length  writer 0 data.
REQ-009 wr_gnt0  output  1  writer 0 owns the write port.
REQ-010 wr_req1, wr_addr1, wr_data1, wr_gnt1 SHALL match REQ-006..REQ-009 for writer 1.
REQ-011 rd_req  input  1  read request.
REQ-012 rd_addr  input  AW  read address.
REQ-013 rd_valid  output  1  rd_data holds the result of the previous cycle's read.
REQ-014 rd_data  output  length  read data.

Function
REQ-015 The block SHALL contain a locations x length memory, with one write port shared by the two writers and one independent read port.
REQ-016 The write arbiter SHALL be a registered FSM with states IDLE, OWN0 and OWN1; wr_gnt0 = (state==OWN0) and wr_gnt1 = (state==OWN1); the grants SHALL be mutually exclusive.
REQ-017 The block SHALL keep a last-served flag and a burst counter of $clog2(burst)+1 bits.
REQ-018 IDLE transitions: only wr_req0 -> OWN0; only wr_req1 -> OWN1; both -> the writer that is not last-served; neither -> IDLE.
REQ-019 A write SHALL occur at a rising edge only when the owner's wr_req is high: memory[wr_addrX] <= wr_data. No write SHALL occur in IDLE.
REQ-020 Request-to-grant latency SHALL be 1 cycle from IDLE; a writer SHALL hold its addr, data and req until it samples its gnt.
REQ-021 In OWNx with wr_reqx low: go to OWNy if wr_reqy is high, else to IDLE; set last-served = x; clear the counter.
REQ-022 In OWNx with wr_reqx high: write, then increment the counter.
REQ-023 When the burst-th consecutive write occurs and wr_reqy is high, the block SHALL move to OWNy, set last-served = x and clear the counter.
REQ-024 When the burst-th consecutive write occurs and wr_reqy is low, the block SHALL stay in OWNx and clear the counter; there SHALL be no forced handover.
REQ-025 Read: when rd_req is high at an edge, rd_data <= memory[rd_addr] and rd_valid <= 1; otherwise rd_valid <= 0 and rd_data holds its value. Latency SHALL be 1 cycle, with one read accepted per cycle.
REQ-026 Read and write to the same address at the same edge SHALL be read-before-write: rd_data returns the old contents, and the new value is visible to reads from the next edge on.
REQ-027 The read port SHALL never stall and SHALL be unaffected by arbiter state.

Reset
REQ-028 While rst is high, asynchronously: state = IDLE, wr_gnt0 = wr_gnt1 = 0, last-served = writer 1 (so writer 0 wins the first tie), counter = 0, rd_valid = 0, rd_data = 0.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 Reset asserted mid-burst SHALL drop the grant immediately, and no write SHALL occur at any edge during reset.
REQ-031 After rst deasserts, the first grant SHALL appear 1 cycle after a request is sampled.

Verification
REQ-032 Single writer: wr_req0 = 1, addr 3, data 0xA for 2 cycles, then rd_req with addr 3 -> wr_gnt0 high from cycle 1; rd_valid = 1 and rd_data = 0xA one cycle after the read request.
REQ-033 Tie after reset: wr_req0 = wr_req1 = 1 held high -> OWN0 for exactly 4 writes, then OWN1 for 4, then OWN0; the grants never overlap.
REQ-034 Lone long burst: wr_req1 held high for 10 cycles, wr_req0 = 0 -> wr_gnt1 stays high for all 10 cycles and 10 writes occur.
REQ-035 Early release: OWN0 with wr_req1 = 1; wr_req0 drops after 2 writes -> next state OWN1, and writer 0 wins the next tie.
REQ-036 Collision: memory[5] = 0x3; at the same edge write 0x9 to addr 5 and read addr 5 -> rd_data = 0x3; a read of addr 5 on the next cycle -> rd_data = 0x9.
REQ-037 Reset mid-burst: rst asserted during the 2nd write of a burst -> gnts and rd_valid go to 0 without waiting for a clock edge; memory is unchanged by the reset cycles.
